// File: rtl/pong_pkg.sv
// pong_pkg: shared state/winner encodings, screen geometry and helpers for the pong design
package pong_pkg;
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SERVE    = 2'd1,
        ST_PLAY     = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int PADDLE_W  = 8;
    localparam int PADDLE_H  = 64;
    localparam int BALL_SIZE = 8;

    function automatic int sat_sub(input int a, input int b, input int lo);
        return (a - b < lo) ? lo : a - b;
    endfunction
endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: pulses into and status/tick outputs out of the game sequencer
interface pong_game_ctrl_if;
    logic       start;
    logic       score_p1;
    logic       score_p2;
    logic       paddle_hit;
    logic       move_tick;
    logic       ball_en;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score_1;
    logic [3:0] score_2;
    logic       game_over;
    logic [1:0] winner;
    logic       flash;

    modport master (
        output start, score_p1, score_p2, paddle_hit,
        input  move_tick, ball_en, ball_reset, serve_dir, score_1, score_2, game_over, winner, flash
    );

    modport slave (
        input  start, score_p1, score_p2, paddle_hit,
        output move_tick, ball_en, ball_reset, serve_dir, score_1, score_2, game_over, winner, flash
    );
endinterface

// File: rtl/pong_tick_gen.sv
// pong_tick_gen: movement prescaler; period is latched at each wrap or clear
module pong_tick_gen #(
    parameter int W    = 17,
    parameter int INIT = 65536
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_period,
    output logic         o_tick
);
    logic [W-1:0] cnt_q, cnt_d, per_q, per_d;
    logic         tick_d, reload;

    // count to period-1, then pulse and reload the period for the next interval
    always_comb begin
        reload = i_clr || !i_en || (cnt_q == per_q - 1'b1);
        tick_d = i_en && !i_clr && (cnt_q == per_q - 1'b1);
        cnt_d  = reload ? '0 : cnt_q + 1'b1;
        per_d  = reload ? i_period : per_q;
    end

    // prescaler registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q  <= '0;
            per_q  <= W'(INIT);
            o_tick <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            o_tick <= tick_d;
        end
    end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer (scores, serve/play timing, game-over flash); PONG_SPEEDUP_EN enables paddle-hit speedup
import pong_pkg::*;

module pong_game_ctrl #(
    parameter int TICK_DIV    = 65536,
    parameter int SERVE_TICKS = 60,
    parameter int SCORE_WIN   = 9,
    parameter int FLASH_BITS  = 24,
    parameter int SPEED_STEP  = 1024,
    parameter int TICK_MIN    = 16384
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    pong_game_ctrl_if.slave  bus
);
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int SW = $clog2(SERVE_TICKS + 1);
`ifdef PONG_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [3:0]            score_1_q, score_1_d, score_2_q, score_2_d;
    logic [1:0]            winner_q, winner_d;
    logic                  serve_dir_q, serve_dir_d, ball_reset_q, ball_reset_d;
    logic                  ball_en_q, ball_en_d, game_over_q, game_over_d, flash_q, flash_d;
    logic [FLASH_BITS-1:0] flash_cnt_q, flash_cnt_d;
    logic [SW-1:0]         serve_cnt_q, serve_cnt_d;
    logic [PW-1:0]         period_q, period_d;
    logic                  move_tick, run;

    pong_tick_gen #(.W(PW), .INIT(TICK_DIV)) u_tick (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_en    (run),
        .i_clr   (bus.start),
        .i_period(period_d),
        .o_tick  (move_tick)
    );

    // next state, scoring, serve timing, flash and tick period
    always_comb begin
        state_d      = state_q;
        score_1_d    = score_1_q;
        score_2_d    = score_2_q;
        winner_d     = winner_q;
        serve_dir_d  = serve_dir_q;
        ball_reset_d = 1'b0;
        flash_d      = flash_q;
        flash_cnt_d  = '0;
        serve_cnt_d  = serve_cnt_q;
        period_d     = period_q;
        if (bus.start) begin
            state_d      = ST_SERVE;
            score_1_d    = '0;
            score_2_d    = '0;
            winner_d     = WIN_NONE;
            serve_dir_d  = 1'b0;
            ball_reset_d = 1'b1;
            flash_d      = 1'b0;
            serve_cnt_d  = '0;
            period_d     = PW'(TICK_DIV);
        end else begin
            case (state_q)
                ST_SERVE: if (move_tick) begin
                    serve_cnt_d = serve_cnt_q + 1'b1;
                    if (serve_cnt_q == SW'(SERVE_TICKS - 1)) state_d = ST_PLAY;
                end
                ST_PLAY: if (bus.score_p1 || bus.score_p2) begin
                    score_1_d   = score_1_q + 4'(bus.score_p1);
                    score_2_d   = score_2_q + 4'(!bus.score_p1);
                    serve_dir_d = bus.score_p1;
                    if (score_1_d == 4'(SCORE_WIN) || score_2_d == 4'(SCORE_WIN)) begin
                        state_d  = ST_GAMEOVER;
                        winner_d = bus.score_p1 ? WIN_P1 : WIN_P2;
                    end else begin
                        state_d      = ST_SERVE;
                        ball_reset_d = 1'b1;
                        serve_cnt_d  = '0;
                        period_d     = PW'(TICK_DIV);
                    end
                end else if (SPEEDUP && bus.paddle_hit) begin
                    period_d = PW'(sat_sub(int'(period_q), SPEED_STEP, TICK_MIN));
                end
                ST_GAMEOVER: begin
                    flash_cnt_d = flash_cnt_q + 1'b1;
                    flash_d     = flash_q ^ (&flash_cnt_q);
                end
                default: ;
            endcase
        end
        run         = (state_d == ST_SERVE) || (state_d == ST_PLAY);
        ball_en_d   = state_d == ST_PLAY;
        game_over_d = state_d == ST_GAMEOVER;
    end

    // state and registered outputs
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= ST_IDLE;
            score_1_q    <= '0;
            score_2_q    <= '0;
            winner_q     <= WIN_NONE;
            serve_dir_q  <= 1'b0;
            ball_reset_q <= 1'b0;
            ball_en_q    <= 1'b0;
            game_over_q  <= 1'b0;
            flash_q      <= 1'b0;
            flash_cnt_q  <= '0;
            serve_cnt_q  <= '0;
            period_q     <= PW'(TICK_DIV);
        end else begin
            state_q      <= state_d;
            score_1_q    <= score_1_d;
            score_2_q    <= score_2_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            ball_reset_q <= ball_reset_d;
            ball_en_q    <= ball_en_d;
            game_over_q  <= game_over_d;
            flash_q      <= flash_d;
            flash_cnt_q  <= flash_cnt_d;
            serve_cnt_q  <= serve_cnt_d;
            period_q     <= period_d;
        end
    end

    assign bus.move_tick  = move_tick;
    assign bus.ball_en    = ball_en_q;
    assign bus.ball_reset = ball_reset_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.score_1    = score_1_q;
    assign bus.score_2    = score_2_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;
    assign bus.flash      = flash_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: vector table, hand sequences and random stimulus against a behavioural match model
module tb_pong_game_ctrl;
    localparam int TICK_DIV = 4, SERVE_TICKS = 2, SCORE_WIN = 3, FLASH_BITS = 3, SPEED_STEP = 1, TICK_MIN = 2;
`ifdef PONG_SPEEDUP_EN
    localparam bit SPD = 1'b1;
`else
    localparam bit SPD = 1'b0;
`endif
    localparam int MI = 0, MS = 1, MP = 2, MG = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pong_game_ctrl_if bus();

    pong_game_ctrl #(
        .TICK_DIV(TICK_DIV), .SERVE_TICKS(SERVE_TICKS), .SCORE_WIN(SCORE_WIN),
        .FLASH_BITS(FLASH_BITS), .SPEED_STEP(SPEED_STEP), .TICK_MIN(TICK_MIN)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_L(rst_n),
        .bus    (bus)
    );

    int checks = 0, passed = 0;

    // behavioural model of the match
    int m_st, m_cnt, m_act, m_per, m_sv, m_fc, m_s1, m_s2, m_win;
    bit m_tick, m_en, m_br, m_dir, m_go, m_fl;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int dut_vec();
        return int'({bus.move_tick, bus.ball_en, bus.ball_reset, bus.serve_dir, bus.score_1,
                     bus.score_2, bus.game_over, bus.winner, bus.flash});
    endfunction

    function automatic int model_vec();
        return int'({m_tick, m_en, m_br, m_dir, 4'(m_s1), 4'(m_s2), m_go, 2'(m_win), m_fl});
    endfunction

    task automatic model_reset();
        m_st = MI; m_cnt = 0; m_act = TICK_DIV; m_per = TICK_DIV; m_sv = 0; m_fc = 0;
        m_s1 = 0; m_s2 = 0; m_win = 0; m_tick = 0; m_en = 0; m_br = 0; m_dir = 0; m_go = 0; m_fl = 0;
    endtask

    task automatic model_step(input bit s, input bit p1, input bit p2, input bit h);
        int nst = m_st;
        int nper = m_per;
        bit br = 0;
        if (s) begin
            nst = MS; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; br = 1; m_sv = 0;
            m_fl = 0; m_fc = 0; nper = TICK_DIV; m_cnt = 0; m_tick = 0; m_act = TICK_DIV;
        end else begin
            if (m_st == MS && m_tick) begin
                m_sv++;
                if (m_sv == SERVE_TICKS) nst = MP;
            end else if (m_st == MP && (p1 || p2)) begin
                if (p1) begin m_s1++; m_dir = 1; end
                else begin m_s2++; m_dir = 0; end
                if (m_s1 == SCORE_WIN || m_s2 == SCORE_WIN) begin
                    nst = MG; m_win = p1 ? 1 : 2;
                end else begin
                    nst = MS; br = 1; m_sv = 0; nper = TICK_DIV;
                end
            end else if (m_st == MP && h && SPD) begin
                nper = (m_per - SPEED_STEP < TICK_MIN) ? TICK_MIN : m_per - SPEED_STEP;
            end else if (m_st == MG) begin
                if (m_fc == (1 << FLASH_BITS) - 1) m_fl = !m_fl;
                m_fc = (m_fc + 1) % (1 << FLASH_BITS);
            end
            if (nst == MS || nst == MP) begin
                if (m_cnt == m_act - 1) begin m_tick = 1; m_cnt = 0; m_act = nper; end
                else begin m_tick = 0; m_cnt++; end
            end else begin
                m_tick = 0; m_cnt = 0;
            end
        end
        m_per = nper; m_st = nst; m_br = br; m_en = (nst == MP); m_go = (nst == MG);
    endtask

    // drive one cycle of inputs, advance to the next negedge and compare with the model
    task automatic step(input bit s, input bit p1, input bit p2, input bit h);
        bus.start = s; bus.score_p1 = p1; bus.score_p2 = p2; bus.paddle_hit = h;
        model_step(s, p1, p2, h);
        @(negedge clk);
        bus.start = 0; bus.score_p1 = 0; bus.score_p2 = 0; bus.paddle_hit = 0;
        chk("model", dut_vec(), model_vec());
    endtask

    task automatic wait_play();
        int n = 0;
        while (!bus.ball_en && n < 40) begin step(0, 0, 0, 0); n++; end
        chk("wait_play", int'(bus.ball_en), 1);
    endtask

    task automatic wait_tick(input bit hit_now, output int n);
        n = 1;
        step(0, 0, 0, hit_now);
        while (!bus.move_tick && n < 20) begin step(0, 0, 0, 0); n++; end
        chk("wait_tick", int'(bus.move_tick), 1);
    endtask

    typedef struct {
        bit start, p1, p2, wait_play;
        int s1, s2, dir, win, go, br;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        vecs[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[1] = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 1};
        vecs[2] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
        vecs[3] = '{0, 1, 1, 1, 2, 1, 1, 0, 0, 1};
        vecs[4] = '{0, 0, 1, 1, 2, 2, 0, 0, 0, 1};
        vecs[5] = '{0, 1, 0, 1, 3, 2, 1, 1, 1, 0};
        bus.start = 0; bus.score_p1 = 0; bus.score_p2 = 0; bus.paddle_hit = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", dut_vec(), 0);
        rst_n = 1'b1;
        step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        chk("idle_scores", int'({bus.score_1, bus.score_2}), 0);
        chk("idle_ball_en", int'(bus.ball_en), 0);
        step(1, 0, 0, 0);
        chk("start_ball_reset", int'(bus.ball_reset), 1);
        chk("start_tick", int'(bus.move_tick), 0);
        for (int k = 2; k <= 10; k++) begin
            step(0, 0, 0, 0);
            chk("serve_tick", int'(bus.move_tick), int'(k == 5 || k == 9));
            chk("serve_ball_en", int'(bus.ball_en), int'(k >= 10));
            chk("ball_reset_once", int'(bus.ball_reset), 0);
        end
        foreach (vecs[i]) begin
            if (vecs[i].wait_play) wait_play();
            step(vecs[i].start, vecs[i].p1, vecs[i].p2, 0);
            chk("vec_score_1", int'(bus.score_1), vecs[i].s1);
            chk("vec_score_2", int'(bus.score_2), vecs[i].s2);
            chk("vec_serve_dir", int'(bus.serve_dir), vecs[i].dir);
            chk("vec_winner", int'(bus.winner), vecs[i].win);
            chk("vec_game_over", int'(bus.game_over), vecs[i].go);
            chk("vec_ball_reset", int'(bus.ball_reset), vecs[i].br);
        end
        for (int k = 1; k <= 17; k++) begin
            step(0, 0, int'(k == 4) != 0, 0);
            chk("go_flash", int'(bus.flash), (k >> 3) & 1);
            chk("go_tick", int'(bus.move_tick), 0);
            chk("go_score_2", int'(bus.score_2), 2);
        end
        step(1, 0, 0, 0);
        chk("restart_scores", int'({bus.score_1, bus.score_2}), 0);
        chk("restart_flash", int'(bus.flash), 0);
        chk("restart_game_over", int'(bus.game_over), 0);
        chk("restart_ball_reset", int'(bus.ball_reset), 1);
        wait_play(); step(0, 1, 0, 0);
        wait_play(); step(0, 1, 0, 0);
        wait_play(); step(0, 0, 1, 0);
        wait_play();
        chk("pre_reset_scores", int'({bus.score_1, bus.score_2}), 8'h21);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", dut_vec(), 0);
        model_reset();
        @(negedge clk);
        chk("reset_hold", dut_vec(), 0);
        rst_n = 1'b1;
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        chk("post_reset_scores", int'({bus.score_1, bus.score_2}), 0);
        chk("post_reset_ball_en", int'(bus.ball_en), 0);
        step(1, 0, 0, 0);
        wait_play();
        wait_tick(0, g);
        wait_tick(1, g); chk("gap_first", g, 4);
        wait_tick(1, g); chk("gap_second", g, SPD ? 3 : 4);
        wait_tick(0, g); chk("gap_saturated", g, SPD ? 2 : 4);
        step(0, 1, 0, 0);
        wait_tick(0, g);
        wait_tick(0, g); chk("gap_after_serve", g, 4);
        step(1, 0, 0, 0);
        for (int k = 0; k < 2500; k++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
